regfile_mbist_ctrl: RTL and testbench

- March C- memory BIST engine for the integer/FP register file.
- Sits directly upstream of the register file test wrapper: drives its BIST enable and 1RW test port (chip select, write enable, address, data), reads back the test read data and reports pass/fail.
- Address 0 is hard-wired, so it is never exercised.
- One clock. Reset is synchronous and active-high.

---
 rtl/regfile_mbist_ctrl.sv | 163 ++++++++++++++++
 tb/tb_regfile_mbist_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mbist_ctrl.sv
// March C- BIST engine for the register file test port.
// Runs M0..M5 over addresses 1..max, with a one-cycle pipelined read compare.
module regfile_mbist_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PATTERN = '0,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  output logic                  bist_o,
  output logic                  csn_t_o,
  output logic                  wen_t_o,
  output logic [ADDR_WIDTH-1:0] a_t_o,
  output logic [DATA_WIDTH-1:0] d_t_o,
  input  logic [DATA_WIDTH-1:0] q_t_i
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] AMAX = '1;
  localparam logic [ADDR_WIDTH-1:0] AMIN = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic                    phase_q, phase_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  logic                    cmp_vld_q;
  logic [DATA_WIDTH-1:0]   exp_q;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q;
  logic [2:0]              cmp_elem_q;

  logic                    fail_q;
  logic [ADDR_WIDTH-1:0]   fail_addr_q;
  logic [2:0]              fail_elem_q;
  logic [DATA_WIDTH-1:0]   fail_data_q;

  logic                    run;
  logic                    is_read;
  logic                    last_op;
  logic                    desc;
  logic                    rd_one;
  logic                    wr_one;
  logic [ADDR_WIDTH-1:0]   end_addr;
  logic                    accept;
  logic                    new_fail;

  // Element 0 is write-only and element 5 read-only; the rest are read then write.
  assign run      = (state_q == RUN);
  assign is_read  = !phase_q && (elem_q != 3'd0);
  assign last_op  = phase_q || (elem_q == 3'd0) || (elem_q == 3'd5);
  assign desc     = (elem_q >= 3'd3);
  assign rd_one   = (elem_q == 3'd2) || (elem_q == 3'd4);
  assign wr_one   = (elem_q == 3'd1) || (elem_q == 3'd3);
  assign end_addr = desc ? AMIN : AMAX;
  assign accept   = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign new_fail = cmp_vld_q && (q_t_i != exp_q) && !fail_q;

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          elem_d  = 3'd0;
          phase_d = 1'b0;
          addr_d  = AMIN;
        end
      end
      RUN: begin
        if (!last_op) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == end_addr) begin
            if (elem_q == 3'd5) begin
              state_d = DRAIN;
            end else begin
              elem_d = elem_q + 3'd1;
              addr_d = (elem_q >= 3'd2) ? AMAX : AMIN;
            end
          end else if (desc) begin
            addr_d = addr_q - AMIN;
          end else begin
            addr_d = addr_q + AMIN;
          end
        end
        if (STOP_ON_FAIL && new_fail) state_d = DONE;
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= 3'd0;
      phase_q     <= 1'b0;
      addr_q      <= '0;
      cmp_vld_q   <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= 3'd0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      fail_data_q <= '0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      phase_q   <= phase_d;
      addr_q    <= addr_d;
      cmp_vld_q <= run && is_read && (state_d != DONE);
      if (run && is_read) begin
        exp_q      <= rd_one ? ~PATTERN : PATTERN;
        cmp_addr_q <= addr_q;
        cmp_elem_q <= elem_q;
      end
      if (accept) begin
        fail_q      <= 1'b0;
        fail_addr_q <= '0;
        fail_elem_q <= 3'd0;
        fail_data_q <= '0;
      end else if (new_fail) begin
        fail_q      <= 1'b1;
        fail_addr_q <= cmp_addr_q;
        fail_elem_q <= cmp_elem_q;
        fail_data_q <= q_t_i;
      end
    end
  end

  assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
  assign bist_o      = busy_o;
  assign done_o      = (state_q == DONE);
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_data_o = fail_data_q;
  assign csn_t_o     = !run;
  assign wen_t_o     = !(run && !is_read);
  assign a_t_o       = run ? addr_q : '0;
  assign d_t_o       = (run && !is_read) ?
                       (wr_one ? ~PATTERN : PATTERN) : '0;

endmodule

// File: tb/tb_regfile_mbist_ctrl.sv
// Bench for regfile_mbist_ctrl: three engines with different
// PATTERN/STOP_ON_FAIL settings, each on a faultable register file model.
module tb_regfile_mbist_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy      [3];
  logic        done      [3];
  logic        fail      [3];
  logic [4:0]  fail_addr [3];
  logic [2:0]  fail_elem [3];
  logic [31:0] fail_data [3];
  logic        bist      [3];
  logic        csn       [3];
  logic        wen       [3];
  logic [4:0]  a         [3];
  logic [31:0] d         [3];
  logic [31:0] q         [3];

  logic [31:0] mem [3][32];
  logic [1:0]  fault [3];

  int checks;
  int failures;

  regfile_mbist_ctrl #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32),
    .PATTERN(32'h0), .STOP_ON_FAIL(1'b1)
  ) u_dut0 (
    .clk(clk), .rst(rst), .start_i(start),
    .busy_o(busy[0]), .done_o(done[0]), .fail_o(fail[0]),
    .fail_addr_o(fail_addr[0]), .fail_elem_o(fail_elem[0]),
    .fail_data_o(fail_data[0]), .bist_o(bist[0]),
    .csn_t_o(csn[0]), .wen_t_o(wen[0]), .a_t_o(a[0]),
    .d_t_o(d[0]), .q_t_i(q[0])
  );

  regfile_mbist_ctrl #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32),
    .PATTERN(32'h0), .STOP_ON_FAIL(1'b0)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start),
    .busy_o(busy[1]), .done_o(done[1]), .fail_o(fail[1]),
    .fail_addr_o(fail_addr[1]), .fail_elem_o(fail_elem[1]),
    .fail_data_o(fail_data[1]), .bist_o(bist[1]),
    .csn_t_o(csn[1]), .wen_t_o(wen[1]), .a_t_o(a[1]),
    .d_t_o(d[1]), .q_t_i(q[1])
  );

  regfile_mbist_ctrl #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32),
    .PATTERN(32'hAAAA_AAAA), .STOP_ON_FAIL(1'b1)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start_i(start),
    .busy_o(busy[2]), .done_o(done[2]), .fail_o(fail[2]),
    .fail_addr_o(fail_addr[2]), .fail_elem_o(fail_elem[2]),
    .fail_data_o(fail_data[2]), .bist_o(bist[2]),
    .csn_t_o(csn[2]), .wen_t_o(wen[2]), .a_t_o(a[2]),
    .d_t_o(d[2]), .q_t_i(q[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fault 1: addr 7 bit 3 stuck-at-1. Fault 2: write to addr 4 flips addr 5 bit 0.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!csn[i]) begin
        if (!wen[i]) begin
          mem[i][a[i]] <= (fault[i] == 2'd1 && a[i] == 5'd7) ?
                          (d[i] | 32'h8) : d[i];
          if (fault[i] == 2'd2 && a[i] == 5'd4)
            mem[i][5] <= mem[i][5] ^ 32'h1;
        end else begin
          q[i] <= mem[i][a[i]];
        end
      end
    end
  end

  int          ops;
  int          reads;
  int          a0err;
  int          bcyc;
  logic [63:0] sig;

  always @(negedge clk) begin
    if (start && !busy[0]) begin
      ops   = 0;
      reads = 0;
      a0err = 0;
      bcyc  = 0;
      sig   = 64'd0;
    end else begin
      if (busy[0]) bcyc++;
      if (!csn[0]) begin
        ops++;
        if (wen[0]) reads++;
        if (a[0] == 5'd0) a0err++;
        sig = {sig[58:0], 5'b0} + sig + 64'({wen[0], a[0], d[0]});
      end
    end
  end

  typedef struct packed {
    logic [1:0]  fault;
    logic        ef;
    logic [4:0]  ea;
    logic [2:0]  ee;
    logic [31:0] ed;
    logic [9:0]  ec;
  } exp_t;

  exp_t        tbl [3][3];
  int          cyc [3];
  logic [127:0] snap;
  logic [63:0] sig0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_test;
    for (int i = 0; i < 3; i++) cyc[i] = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    snap = 128'({done[0], fail[0], busy[0], csn[0], wen[0], a[0],
                 fail_addr[0]});
    for (int n = 1; n <= 400 && !(done[0] && done[1] && done[2]); n++) begin
      tick();
      for (int i = 0; i < 3; i++)
        if (done[i] && cyc[i] < 0) cyc[i] = n;
    end
  endtask

  logic [127:0] rst_exp;

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) fault[i] = 2'd0;
    rst_exp = 128'({1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'd0,
                    1'b0, 1'b1, 1'b1, 5'd0, 32'd0});

    tbl[0][0] = '{2'd0, 1'b0, 5'd0, 3'd0, 32'h0, 10'd311};
    tbl[0][1] = '{2'd0, 1'b0, 5'd0, 3'd0, 32'h0, 10'd311};
    tbl[0][2] = '{2'd0, 1'b0, 5'd0, 3'd0, 32'h0, 10'd311};
    tbl[1][0] = '{2'd1, 1'b1, 5'd7, 3'd1, 32'h0000_0008, 10'd45};
    tbl[1][1] = '{2'd1, 1'b1, 5'd7, 3'd1, 32'h0000_0008, 10'd311};
    tbl[1][2] = '{2'd2, 1'b1, 5'd5, 3'd1, 32'hAAAA_AAAB, 10'd41};
    tbl[2][0] = '{2'd2, 1'b1, 5'd5, 3'd1, 32'h0000_0001, 10'd41};
    tbl[2][1] = '{2'd2, 1'b1, 5'd5, 3'd1, 32'h0000_0001, 10'd311};
    tbl[2][2] = '{2'd1, 1'b1, 5'd7, 3'd2, 32'h5555_555D, 10'd107};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_state", 128'({busy[0], done[0], fail[0], fail_addr[0],
        fail_elem[0], fail_data[0], bist[0], csn[0], wen[0], a[0], d[0]}),
        rst_exp);

    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 3; i++) fault[i] = tbl[v][i].fault;
      run_test();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("v%0d_i%0d_fail", v, i), 128'(fail[i]),
            128'(tbl[v][i].ef));
        chk($sformatf("v%0d_i%0d_addr", v, i), 128'(fail_addr[i]),
            128'(tbl[v][i].ea));
        chk($sformatf("v%0d_i%0d_elem", v, i), 128'(fail_elem[i]),
            128'(tbl[v][i].ee));
        chk($sformatf("v%0d_i%0d_data", v, i), 128'(fail_data[i]),
            128'(tbl[v][i].ed));
        chk($sformatf("v%0d_i%0d_cycles", v, i), 128'(cyc[i]),
            128'(tbl[v][i].ec));
        chk($sformatf("v%0d_i%0d_idle_port", v, i),
            128'({busy[i], bist[i], csn[i]}), 128'(3'b001));
      end
      if (v == 0) begin
        chk("clean_ops", 128'(ops), 128'(310));
        chk("clean_reads", 128'(reads), 128'(155));
        chk("clean_addr0", 128'(a0err), 128'(0));
        chk("clean_busy_cycles", 128'(bcyc), 128'(311));
        sig0 = sig;
      end
    end

    // Back-to-back start while done=1 and fail=1 from the previous run.
    for (int i = 0; i < 3; i++) fault[i] = 2'd0;
    run_test();
    chk("b2b_first_cycle", snap,
        128'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd0}));
    chk("b2b_cycles", 128'(cyc[0]), 128'(311));
    chk("b2b_fail", 128'(fail[0]), 128'(0));
    chk("b2b_sequence", 128'(sig), 128'(sig0));

    // Start during RUN is ignored; reset at op 100 aborts.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (49) tick();
    chk("op100_no_restart",
        128'({busy[0], csn[0], wen[0], a[0], d[0]}),
        128'({1'b1, 1'b0, 1'b0, 5'd4, 32'd0}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_reset_state", 128'({busy[0], done[0], fail[0], fail_addr[0],
        fail_elem[0], fail_data[0], bist[0], csn[0], wen[0], a[0], d[0]}),
        rst_exp);
    chk("midrun_reset_all", 128'({bist[1], csn[1], bist[2], csn[2]}),
        128'(4'b0101));
    tick();
    chk("after_reset_idle", 128'({busy[0], done[0], csn[0]}), 128'(3'b001));
    run_test();
    chk("rerun_cycles", 128'(cyc[0]), 128'(311));
    chk("rerun_fail", 128'(fail[0]), 128'(0));
    chk("rerun_sequence", 128'(sig), 128'(sig0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
